// File: rtl/rat_pkg.sv
// Shared widths, tag types and reset-map helper for the register alias table.
package rat_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int aw_of(input int narch);
        return clog2_min1(narch);
    endfunction

    function automatic int pw_of(input int nphys);
        return clog2_min1(nphys);
    endfunction

    function automatic int cw_of(input int nckpt);
        return clog2_min1(nckpt);
    endfunction

    localparam int RAT_NARCH = 32;
    localparam int RAT_NPHYS = 64;
    localparam int RAT_NCKPT = 4;

    typedef logic [aw_of(RAT_NARCH)-1:0] arch_idx_t;
    typedef logic [pw_of(RAT_NPHYS)-1:0] phys_tag_t;
    typedef logic [cw_of(RAT_NCKPT)-1:0] ckpt_ptr_t;

    // Reset tag of arch register i: identity, or mirrored when rev is set.
    function automatic int init_map(input int i, input int narch, input bit rev);
        return rev ? (narch - 1 - i) : i;
    endfunction

endpackage

// File: rtl/rat_ckpt_ring.sv
// Branch checkpoint ring: head/tail/count pointers plus full-map snapshots.
// Only instantiated when RAT_CKPT_EN is defined.
module rat_ckpt_ring
    import rat_pkg::*;
#(
    parameter int NARCH = 32,
    parameter int PW    = 6,
    parameter int NCKPT = 4,
    parameter int CW    = cw_of(NCKPT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       overwrite,
    input  logic                       restore,
    input  logic [CW-1:0]              restore_id,
    input  logic                       ckpt_req,
    input  logic                       ckpt_free,
    input  logic [NARCH-1:0][PW-1:0]   snap_in,
    output logic [NARCH-1:0][PW-1:0]   snap_out,
    output logic                       ckpt_ready,
    output logic [CW-1:0]              ckpt_id
);

    logic [CW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW:0]   count_q, count_d;
    logic [NCKPT-1:0][NARCH-1:0][PW-1:0] snap_q, snap_d;
    logic take, rel;

    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == CW'(NCKPT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ckpt_ready = (count_q != (CW+1)'(NCKPT));
    assign ckpt_id    = tail_q;
    assign snap_out   = snap_q[restore_id];

    // A release in the same cycle frees the slot a full ring needs for the new snapshot.
    assign rel  = ckpt_free && (count_q != '0);
    assign take = ckpt_req && (ckpt_ready || rel);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        snap_d  = snap_q;
        if (!stall) begin
            if (overwrite) begin
                head_d  = tail_q;
                count_d = '0;
            end else if (restore) begin
                tail_d  = restore_id;
                count_d = {1'b0, CW'(restore_id - head_q)};
            end else begin
                if (take) begin
                    snap_d[tail_q] = snap_in;
                    tail_d         = ptr_inc(tail_q);
                end
                if (rel) head_d = ptr_inc(head_q);
                count_d = count_q + (CW+1)'(take) - (CW+1)'(rel);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            snap_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            snap_q  <= snap_d;
        end
    end

endmodule

// File: rtl/rename_map_table.sv
// Multi-port register alias table with intra-group bypass and optional
// checkpoint/restore ring (enabled by defining RAT_CKPT_EN).
module rename_map_table
    import rat_pkg::*;
#(
    parameter int W            = 2,
    parameter int NARCH        = 32,
    parameter int NPHYS        = 64,
    parameter int NCKPT        = 4,
    parameter int INIT_REVERSE = 0,
    parameter int AW           = aw_of(NARCH),
    parameter int PW           = pw_of(NPHYS),
    parameter int CW           = cw_of(NCKPT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [W*3*AW-1:0]     src_arch,
    output logic [W*3*PW-1:0]     src_phys,
    input  logic [W-1:0]          dst_valid,
    input  logic [W*AW-1:0]       dst_arch,
    input  logic [W*PW-1:0]       dst_phys,
    output logic [W*PW-1:0]       dst_old,
    input  logic                  overwrite,
    input  logic [NARCH*PW-1:0]   new_map,
    output logic [NARCH*PW-1:0]   my_map,
    input  logic                  ckpt_req,
    output logic                  ckpt_ready,
    output logic [CW-1:0]         ckpt_id,
    input  logic                  ckpt_free,
    input  logic                  restore,
    input  logic [CW-1:0]         restore_id
);

    typedef logic [NARCH-1:0][PW-1:0] map_t;

    map_t map_q, map_d, map_rm, ckpt_map;
    logic rst_hit;

    logic [W-1:0][2:0][AW-1:0] s_arch;
    logic [W-1:0][2:0][PW-1:0] s_phys;
    logic [W-1:0][AW-1:0]      d_arch;
    logic [W-1:0][PW-1:0]      d_phys, d_old;

    assign s_arch   = src_arch;
    assign d_arch   = dst_arch;
    assign d_phys   = dst_phys;
    assign src_phys = s_phys;
    assign dst_old  = d_old;
    assign my_map   = map_q;

    // Younger slots see the newest older-slot write to the same register.
    always_comb begin
        s_phys = '0;
        d_old  = '0;
        for (int s = 0; s < W; s++) begin
            for (int k = 0; k < 3; k++) begin
                s_phys[s][k] = map_q[s_arch[s][k]];
                for (int j = 0; j < s; j++)
                    if (dst_valid[j] && d_arch[j] == s_arch[s][k]) s_phys[s][k] = d_phys[j];
            end
            d_old[s] = map_q[d_arch[s]];
            for (int j = 0; j < s; j++)
                if (dst_valid[j] && d_arch[j] == d_arch[s]) d_old[s] = d_phys[j];
        end
    end

    always_comb begin
        map_rm = map_q;
        for (int s = 0; s < W; s++)
            if (dst_valid[s]) map_rm[d_arch[s]] = d_phys[s];
        map_d = map_q;
        if (!stall) begin
            if (overwrite)    map_d = new_map;
            else if (rst_hit) map_d = ckpt_map;
            else              map_d = map_rm;
        end
    end

`ifdef RAT_CKPT_EN
    assign rst_hit = restore;

    // Snapshot captures the post-remap map so the branch's own group is kept.
    rat_ckpt_ring #(
        .NARCH (NARCH),
        .PW    (PW),
        .NCKPT (NCKPT),
        .CW    (CW)
    ) u_ring (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .overwrite  (overwrite),
        .restore    (restore),
        .restore_id (restore_id),
        .ckpt_req   (ckpt_req),
        .ckpt_free  (ckpt_free),
        .snap_in    (map_rm),
        .snap_out   (ckpt_map),
        .ckpt_ready (ckpt_ready),
        .ckpt_id    (ckpt_id)
    );
`else
    logic unused_ckpt;
    assign rst_hit     = 1'b0;
    assign ckpt_map    = map_q;
    assign ckpt_ready  = 1'b0;
    assign ckpt_id     = '0;
    assign unused_ckpt = ^{ckpt_req, ckpt_free, restore, restore_id};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NARCH; i++)
                map_q[i] <= PW'(init_map(i, NARCH, INIT_REVERSE != 0));
        end else begin
            map_q <= map_d;
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Directed plus randomized bench for rename_map_table against an array/ring reference model.
module tb_rename_map_table;

    localparam int W = 2, NARCH = 32, NPHYS = 64, NCKPT = 4;
    localparam int AW = 5, PW = 6, CW = 2;
`ifdef RAT_CKPT_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic stall = 1'b0, overwrite = 1'b0, ckpt_req = 1'b0, ckpt_free = 1'b0, restore = 1'b0;
    logic [W*3*AW-1:0]   src_arch = '0;
    logic [W*3*PW-1:0]   src_phys;
    logic [W-1:0]        dst_valid = '0;
    logic [W*AW-1:0]     dst_arch = '0;
    logic [W*PW-1:0]     dst_phys = '0;
    logic [W*PW-1:0]     dst_old;
    logic [NARCH*PW-1:0] new_map = '0;
    logic [NARCH*PW-1:0] my_map;
    logic                ckpt_ready;
    logic [CW-1:0]       ckpt_id;
    logic [CW-1:0]       restore_id = '0;

    rename_map_table #(.W(W), .NARCH(NARCH), .NPHYS(NPHYS), .NCKPT(NCKPT), .INIT_REVERSE(0)) dut (
        .clk(clk), .reset(rst_n), .stall(stall),
        .src_arch(src_arch), .src_phys(src_phys),
        .dst_valid(dst_valid), .dst_arch(dst_arch), .dst_phys(dst_phys), .dst_old(dst_old),
        .overwrite(overwrite), .new_map(new_map), .my_map(my_map),
        .ckpt_req(ckpt_req), .ckpt_ready(ckpt_ready), .ckpt_id(ckpt_id),
        .ckpt_free(ckpt_free), .restore(restore), .restore_id(restore_id)
    );

    always #5 clk = ~clk;

    // Reference state: map as plain ints, checkpoints as a head/count ring.
    int mmap[NARCH];
    int ck[NCKPT][NARCH];
    int head, cnt;
    int pass_n = 0, total_n = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NARCH; i++) mmap[i] = i;
        head = 0;
        cnt  = 0;
    endtask

    function automatic int lk(input int s, input int a);
        int r = mmap[a];
        for (int j = 0; j < s; j++)
            if (dst_valid[j] && int'(dst_arch[j*AW +: AW]) == a) r = int'(dst_phys[j*PW +: PW]);
        return r;
    endfunction

    task automatic check_all(input string tag);
        logic [W*3*PW-1:0]   es;
        logic [W*PW-1:0]     eo;
        logic [NARCH*PW-1:0] em;
        for (int s = 0; s < W; s++) begin
            for (int k = 0; k < 3; k++)
                es[(s*3+k)*PW +: PW] = PW'(lk(s, int'(src_arch[(s*3+k)*AW +: AW])));
            eo[s*PW +: PW] = PW'(lk(s, int'(dst_arch[s*AW +: AW])));
        end
        for (int i = 0; i < NARCH; i++) em[i*PW +: PW] = PW'(mmap[i]);
        chk({tag, ".src"}, 256'(src_phys), 256'(es));
        chk({tag, ".old"}, 256'(dst_old), 256'(eo));
        chk({tag, ".map"}, 256'(my_map), 256'(em));
        chk({tag, ".ready"}, 256'(ckpt_ready), 256'(CK && cnt != NCKPT));
        chk({tag, ".id"}, 256'(ckpt_id), CK ? 256'((head + cnt) % NCKPT) : 256'(0));
    endtask

    task automatic model_next();
        int nm[NARCH];
        int tl;
        bit take, rel;
        if (stall) return;
        nm = mmap;
        for (int s = 0; s < W; s++)
            if (dst_valid[s]) nm[int'(dst_arch[s*AW +: AW])] = int'(dst_phys[s*PW +: PW]);
        tl = (head + cnt) % NCKPT;
        if (overwrite) begin
            for (int i = 0; i < NARCH; i++) mmap[i] = int'(new_map[i*PW +: PW]);
            head = tl;
            cnt  = 0;
        end else if (CK && restore) begin
            mmap = ck[int'(restore_id)];
            cnt  = (int'(restore_id) - head + NCKPT) % NCKPT;
        end else begin
            mmap = nm;
            rel  = CK && ckpt_free && cnt > 0;
            take = CK && ckpt_req && (cnt < NCKPT || rel);
            if (take) ck[tl] = nm;
            if (rel) head = (head + 1) % NCKPT;
            cnt = cnt + int'(take) - int'(rel);
        end
    endtask

    task automatic clear_pulses();
        stall = 0; dst_valid = '0; ckpt_req = 0; ckpt_free = 0; restore = 0; overwrite = 0;
    endtask

    // Inputs are set just after a falling edge; checked 1 time unit later.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        model_next();
        @(posedge clk);
        @(negedge clk);
        clear_pulses();
    endtask

    task automatic rand_map();
        for (int i = 0; i < NARCH; i++) new_map[i*PW +: PW] = PW'($urandom_range(NPHYS-1));
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        @(negedge clk);

        // T1 reset image
        src_arch[0 +: AW] = AW'(5);
        #1;
        chk("t1.srcA", 256'(src_phys[0 +: PW]), 256'(5));
        chk("t1.map31", 256'(my_map[31*PW +: PW]), 256'(31));
        chk("t1.ready", 256'(ckpt_ready), 256'(CK));
        chk("t1.id", 256'(ckpt_id), 256'(0));
        cycle("t1");

        // T2 bypass and same-register write ordering
        dst_valid = 2'b01; dst_arch[0 +: AW] = AW'(3); dst_phys[0 +: PW] = PW'(40);
        src_arch[3*AW +: AW] = AW'(3);
        #1;
        chk("t2.byp", 256'(src_phys[3*PW +: PW]), 256'(40));
        chk("t2.old0", 256'(dst_old[0 +: PW]), 256'(3));
        cycle("t2a");
        dst_valid = 2'b11; dst_arch = {AW'(3), AW'(3)}; dst_phys = {PW'(41), PW'(40)};
        cycle("t2b");
        #1;
        chk("t2.map3", 256'(my_map[3*PW +: PW]), 256'(41));

        // T3 checkpoint then restore
        dst_valid = 2'b01; dst_arch[0 +: AW] = AW'(1); dst_phys[0 +: PW] = PW'(50); ckpt_req = 1;
        cycle("t3c0");
        dst_valid = 2'b01; dst_arch[0 +: AW] = AW'(1); dst_phys[0 +: PW] = PW'(51);
        cycle("t3c1");
        restore = 1; restore_id = '0;
        dst_valid = 2'b01; dst_arch[0 +: AW] = AW'(1); dst_phys[0 +: PW] = PW'(52);
        cycle("t3c2");
        #1;
        chk("t3.map1", 256'(my_map[1*PW +: PW]), CK ? 256'(50) : 256'(52));
        chk("t3.id", 256'(ckpt_id), 256'(0));

        // T4 fill ring, ignored fifth request, free+req when full
        for (int i = 0; i < 4; i++) begin
            ckpt_req = 1; dst_valid = 2'b01;
            dst_arch[0 +: AW] = AW'(i + 8); dst_phys[0 +: PW] = PW'(20 + i);
            cycle("t4fill");
        end
        #1;
        chk("t4.full", 256'(ckpt_ready), 256'(0));
        ckpt_req = 1;
        cycle("t4fifth");
        ckpt_req = 1; ckpt_free = 1;
        cycle("t4both");
        #1;
        chk("t4.tail", 256'(ckpt_id), CK ? 256'(1) : 256'(0));
        chk("t4.stillfull", 256'(ckpt_ready), 256'(0));
        restore = 1; restore_id = CW'(2);
        cycle("t4rest");

        // T5 priority and stall
        ckpt_req = 1; cycle("t5ck");
        rand_map();
        overwrite = 1; restore = 1; restore_id = CW'(head); dst_valid = 2'b11;
        ckpt_req = 1; ckpt_free = 1;
        cycle("t5ow");
        #1;
        chk("t5.newmap", 256'(my_map), 256'(new_map));
        ckpt_req = 1; cycle("t5ck2");
        rand_map();
        stall = 1; overwrite = 1; restore = 1; restore_id = CW'(head);
        dst_valid = 2'b11; ckpt_req = 1; ckpt_free = 1;
        cycle("t5stall");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            src_arch  = {$urandom, $urandom};
            dst_valid = W'($urandom);
            dst_arch  = W*AW'($urandom);
            dst_phys  = W*PW'($urandom);
            stall     = ($urandom_range(7) == 0);
            ckpt_req  = $urandom_range(1);
            ckpt_free = ($urandom_range(2) == 0);
            if ($urandom_range(31) == 0) begin
                overwrite = 1;
                rand_map();
            end
            if (cnt > 0 && $urandom_range(5) == 0) begin
                restore    = 1;
                restore_id = CW'((head + int'($urandom_range(cnt - 1))) % NCKPT);
            end else if (!CK && $urandom_range(3) == 0) begin
                restore    = 1;
                restore_id = CW'($urandom);
            end
            cycle("rnd");
        end

        // Reset in the middle of a pending restore
        ckpt_req = 1; cycle("pre_rst");
        restore = 1; restore_id = CW'(head); dst_valid = 2'b11;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("in_rst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        clear_pulses();
        cycle("post_rst");
        cycle("post_rst2");

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
